// File: rtl/watch_mode_ctrl.sv
// Wristwatch mode controller: on-chip button conditioning, display state, stopwatch/alarm flags.
// Raw press to registered output is DEBOUNCE_CYCLES+3 cycles; no backpressure, events are never queued.
module watch_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter bit ALARM_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_time_set,
    input  logic       btn_increment,
    input  logic       btn_decrement,
    output logic [2:0] state,
    output logic       run_time,
    output logic       run_stopwatch,
    output logic       reset_stopwatch,
    output logic       inc_h,
    output logic       dec_h,
    output logic       inc_m,
    output logic       dec_m,
    output logic       al_inc_h,
    output logic       al_dec_h,
    output logic       al_inc_m,
    output logic       al_dec_m,
    output logic       alarm_armed
);

    typedef enum logic [2:0] {
        ST_TIME  = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2,
        ST_SW    = 3'd3,
        ST_AL_H  = 3'd4,
        ST_AL_M  = 3'd5
    } state_t;

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RP_DLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RP_PER  = RW'(REPEAT_PERIOD);
    localparam bit            REP_EN  = (REPEAT_DELAY != 0);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

    // Button index: 0 mode, 1 time_set, 2 increment, 3 decrement
    logic [3:0]    w_btn;
    logic [3:0]    r_sync1, r_sync2, r_deb, r_deb_d;
    logic [DW-1:0] r_db_cnt [4];
    logic [3:0]    w_press;

    logic [RW-1:0] r_rep_cnt [2];
    logic [1:0]    r_rep_late;
    logic [1:0]    w_rep_fire;

    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    state_t        r_state, w_state_nxt;
    logic          w_set_st, w_chg;
    logic          w_raw_inc, w_raw_dec, w_any_ev;
    logic          w_ev_set, w_ev_mode, w_ev_inc, w_ev_dec;

    logic          r_run_time, r_run_sw, r_rst_sw, r_armed;
    logic [7:0]    r_pulse;
    logic          w_run_time_n, w_run_sw_n, w_rst_sw_n, w_armed_n;
    logic [7:0]    w_pulse_n;

    assign w_btn = {btn_decrement, btn_increment, btn_time_set, btn_mode};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press  = r_deb & ~r_deb_d;
    assign w_set_st = (r_state == ST_SET_H) || (r_state == ST_SET_M) ||
                      (r_state == ST_AL_H)  || (r_state == ST_AL_M);

    // Repeat count runs from 1 at the press; a zero count means disarmed
    always_comb begin
        w_rep_fire = '0;
        for (int j = 0; j < 2; j++) begin
            w_rep_fire[j] = REP_EN && w_set_st && r_deb[2+j] && (r_rep_cnt[j] != '0) &&
                            (r_rep_cnt[j] == (r_rep_late[j] ? RP_PER : RP_DLY));
        end
    end

    assign w_raw_inc = w_press[2] | w_rep_fire[0];
    assign w_raw_dec = w_press[3] | w_rep_fire[1];
    assign w_any_ev  = w_press[1] | w_press[0] | w_raw_inc | w_raw_dec;
    assign w_ev_set  = w_press[1];
    assign w_ev_mode = w_press[0] & ~w_press[1];
    assign w_ev_inc  = w_raw_inc & ~w_press[1] & ~w_press[0];
    assign w_ev_dec  = w_raw_dec & ~w_raw_inc & ~w_press[1] & ~w_press[0];
    assign w_timeout = TO_EN && w_set_st && !w_any_ev && (r_to_cnt == TO_LAST);
    assign w_chg     = (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep_late <= '0;
            r_to_cnt   <= '0;
            for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!REP_EN || w_chg || !w_set_st || !r_deb[2+j]) begin
                    r_rep_cnt[j]  <= '0;
                    r_rep_late[j] <= 1'b0;
                end else if (w_press[2+j]) begin
                    r_rep_cnt[j]  <= RW'(1);
                    r_rep_late[j] <= 1'b0;
                end else if (w_rep_fire[j]) begin
                    r_rep_cnt[j]  <= RW'(1);
                    r_rep_late[j] <= 1'b1;
                end else if (r_rep_cnt[j] != '0) begin
                    r_rep_cnt[j]  <= r_rep_cnt[j] + 1'b1;
                end
            end
            if (!TO_EN || !w_set_st || w_chg || w_any_ev) r_to_cnt <= '0;
            else                                          r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_TIME;
            r_run_time <= 1'b1;
            r_run_sw   <= 1'b0;
            r_rst_sw   <= 1'b0;
            r_armed    <= 1'b0;
            r_pulse    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_time <= w_run_time_n;
            r_run_sw   <= w_run_sw_n;
            r_rst_sw   <= w_rst_sw_n;
            r_armed    <= w_armed_n;
            r_pulse    <= w_pulse_n;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_TIME: begin
                if (w_ev_set)                   w_state_nxt = ST_SET_H;
                else if (w_ev_mode)             w_state_nxt = ST_SW;
                else if (w_ev_dec && ALARM_EN)  w_state_nxt = ST_AL_H;
            end
            ST_SET_H: if (w_ev_set) w_state_nxt = ST_SET_M;
            ST_SET_M: if (w_ev_set) w_state_nxt = ST_TIME;
            ST_SW:    if (w_ev_mode) w_state_nxt = ST_TIME;
            ST_AL_H:  if (w_ev_set) w_state_nxt = ST_AL_M;
            ST_AL_M:  if (w_ev_set) w_state_nxt = ST_TIME;
            default:  w_state_nxt = ST_TIME;
        endcase
        if (w_timeout) w_state_nxt = ST_TIME;
    end

    // Pulse vector order: {al_dec_m, al_inc_m, al_dec_h, al_inc_h, dec_m, inc_m, dec_h, inc_h}
    always_comb begin
        w_pulse_n  = '0;
        w_rst_sw_n = 1'b0;
        w_run_sw_n = r_run_sw;
        w_armed_n  = r_armed;
        case (r_state)
            ST_TIME: if (w_ev_inc && ALARM_EN) w_armed_n = ~r_armed;
            ST_SET_H: begin
                w_pulse_n[0] = w_ev_inc;
                w_pulse_n[1] = w_ev_dec;
            end
            ST_SET_M: begin
                w_pulse_n[2] = w_ev_inc;
                w_pulse_n[3] = w_ev_dec;
            end
            ST_SW: begin
                if (w_ev_inc) w_run_sw_n = ~r_run_sw;
                if (w_ev_dec) begin
                    w_run_sw_n = 1'b0;
                    w_rst_sw_n = 1'b1;
                end
            end
            ST_AL_H: begin
                w_pulse_n[4] = w_ev_inc;
                w_pulse_n[5] = w_ev_dec;
            end
            ST_AL_M: begin
                w_pulse_n[6] = w_ev_inc;
                w_pulse_n[7] = w_ev_dec;
            end
            default: ;
        endcase
        w_run_time_n = !((w_state_nxt == ST_SET_H) || (w_state_nxt == ST_SET_M));
    end

    assign state           = r_state;
    assign run_time        = r_run_time;
    assign run_stopwatch   = r_run_sw;
    assign reset_stopwatch = r_rst_sw;
    assign alarm_armed     = r_armed;
    assign inc_h           = r_pulse[0];
    assign dec_h           = r_pulse[1];
    assign inc_m           = r_pulse[2];
    assign dec_m           = r_pulse[3];
    assign al_inc_h        = r_pulse[4];
    assign al_dec_h        = r_pulse[5];
    assign al_inc_m        = r_pulse[6];
    assign al_dec_m        = r_pulse[7];

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with DEBOUNCE=4, REPEAT 16/4, TIMEOUT=64.
module tb_watch_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_time_set = 1'b0, btn_increment = 1'b0, btn_decrement = 1'b0;
    logic [2:0] state;
    logic       run_time, run_stopwatch, reset_stopwatch;
    logic       inc_h, dec_h, inc_m, dec_m, al_inc_h, al_dec_h, al_inc_m, al_dec_m, alarm_armed;

    localparam logic [3:0] B_MODE = 4'b0001;
    localparam logic [3:0] B_SET  = 4'b0010;
    localparam logic [3:0] B_INC  = 4'b0100;
    localparam logic [3:0] B_DEC  = 4'b1000;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_inc_h = 0, n_dec_h = 0, n_inc_m = 0, n_dec_m = 0;
    int n_al_inc_h = 0, n_al_dec_m = 0, n_rst_sw = 0;
    int q_inc_m [$];
    int t0;

    watch_mode_ctrl #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(4),
        .TIMEOUT_CYCLES(64), .ALARM_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_time_set(btn_time_set),
        .btn_increment(btn_increment), .btn_decrement(btn_decrement),
        .state(state), .run_time(run_time), .run_stopwatch(run_stopwatch),
        .reset_stopwatch(reset_stopwatch),
        .inc_h(inc_h), .dec_h(dec_h), .inc_m(inc_m), .dec_m(dec_m),
        .al_inc_h(al_inc_h), .al_dec_h(al_dec_h), .al_inc_m(al_inc_m), .al_dec_m(al_dec_m),
        .alarm_armed(alarm_armed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (inc_h)           n_inc_h++;
        if (dec_h)           n_dec_h++;
        if (inc_m)           begin n_inc_m++; q_inc_m.push_back(cyc); end
        if (dec_m)           n_dec_m++;
        if (al_inc_h)        n_al_inc_h++;
        if (al_dec_m)        n_al_dec_m++;
        if (reset_stopwatch) n_rst_sw++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_decrement, btn_increment, btn_time_set, btn_mode} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        @(posedge clk); #1;
        set_btns(m);
        repeat (hold) @(posedge clk);
        #1 set_btns(4'b0000);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_run_time", run_time, 1);
        check("rst_run_sw", run_stopwatch, 0);
        check("rst_armed", alarm_armed, 0);
        check("rst_pulses", {inc_h, dec_h, inc_m, dec_m, al_inc_h, al_dec_h, al_inc_m, al_dec_m, reset_stopwatch}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Bouncy mode press: three 2-cycle glitches, then a stable level
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            btn_mode = 1'b1;
            repeat (2) @(posedge clk);
            #1 btn_mode = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        btn_mode = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("bounce_pre", state, 0);
        @(posedge clk); #1;
        check("bounce_lat", state, 3);
        repeat (3) @(posedge clk);
        #1 btn_mode = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("bounce_release", state, 3);

        // Stopwatch flag independent of display state
        press(B_INC, 6);
        check("sw_run_on", run_stopwatch, 1);
        press(B_MODE, 6);
        check("sw_to_time", state, 0);
        check("sw_run_kept", run_stopwatch, 1);
        press(B_MODE, 6);
        check("sw_back", state, 3);
        press(B_DEC, 6);
        check("sw_rst_pulse", n_rst_sw, 1);
        check("sw_run_off", run_stopwatch, 0);
        press(B_MODE, 6);
        check("sw_exit", state, 0);

        // Time set flow
        press(B_SET, 6);
        check("set_h", state, 1);
        check("set_h_run_time", run_time, 0);
        press(B_INC, 6);
        press(B_INC, 6);
        press(B_DEC, 6);
        check("set_inc_h", n_inc_h, 2);
        check("set_dec_h", n_dec_h, 1);
        press(B_SET, 6);
        check("set_m", state, 2);
        check("set_m_run_time", run_time, 0);
        press(B_DEC, 6);
        check("set_dec_m", n_dec_m, 1);
        check("set_inc_m_none", n_inc_m, 0);
        press(B_SET, 6);
        check("set_done", state, 0);
        check("set_done_run_time", run_time, 1);

        // Hold-to-repeat in SET_M
        press(B_SET, 6);
        press(B_SET, 6);
        check("rep_in_set_m", state, 2);
        q_inc_m.delete();
        @(posedge clk); #1;
        t0 = cyc;
        btn_increment = 1'b1;
        repeat (40) @(posedge clk);
        #1 btn_increment = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("rep_count", q_inc_m.size(), 7);
        if (q_inc_m.size() == 7) begin
            check("rep_first_lat", q_inc_m[0] - t0, 7);
            check("rep_delay", q_inc_m[1] - q_inc_m[0], 16);
            check("rep_period", q_inc_m[2] - q_inc_m[1], 4);
            check("rep_last", q_inc_m[6] - q_inc_m[0], 36);
        end
        press(B_SET, 6);
        check("rep_exit", state, 0);

        // Set-state timeout
        press(B_SET, 6);
        repeat (40) @(posedge clk);
        #1 check("to_before", state, 1);
        repeat (20) @(posedge clk);
        #1 check("to_after", state, 0);
        check("to_run_time", run_time, 1);
        check("to_edits_kept", n_inc_h, 2);

        // Simultaneous time_set + inc in SET_H
        press(B_SET, 6);
        press(B_SET | B_INC, 6);
        check("simul_state", state, 2);
        check("simul_no_inc_h", n_inc_h, 2);
        press(B_SET, 6);
        check("simul_exit", state, 0);

        // Alarm arm and alarm set states
        press(B_INC, 6);
        check("al_armed", alarm_armed, 1);
        press(B_DEC, 6);
        check("al_set_h", state, 4);
        press(B_INC, 6);
        check("al_inc_h", n_al_inc_h, 1);
        press(B_SET, 6);
        check("al_set_m", state, 5);
        press(B_DEC, 6);
        check("al_dec_m", n_al_dec_m, 1);
        press(B_SET, 6);
        check("al_exit", state, 0);
        check("al_no_time_edit", n_inc_h + n_dec_h + n_dec_m, 4);

        // Asynchronous reset in SET_M with the stopwatch running
        press(B_MODE, 6);
        press(B_INC, 6);
        press(B_MODE, 6);
        press(B_SET, 6);
        press(B_SET, 6);
        check("mid_state", state, 2);
        check("mid_run_sw", run_stopwatch, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_run_time", run_time, 1);
        check("async_run_sw", run_stopwatch, 0);
        check("async_armed", alarm_armed, 0);

        // Button held through reset release yields exactly one press
        btn_mode = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("held_reset_press", state, 3);
        btn_mode = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("held_reset_release", state, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
